// File: rtl/pipeline_solver.sv
// Recovers A and R from X = A*B + C by computing (X - C) / B with a
// 14-step restoring divider; results are held until the next accepted start.
module pipeline_solver (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] X,
    input  logic [9:0]  B,
    input  logic [9:0]  C,
    output logic [9:0]  A,
    output logic [9:0]  R,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_DIV0  = 2'b01;
    localparam logic [1:0] ERR_UNDER = 2'b10;
    localparam logic [1:0] ERR_OVER  = 2'b11;

    state_t      state_reg, state_next;
    logic [13:0] x_reg;
    logic [9:0]  b_reg;
    logic [9:0]  c_reg;
    logic [13:0] d_reg;
    logic [14:0] rem_reg;
    logic [13:0] quo_reg;
    logic [3:0]  cnt_reg;
    logic [9:0]  a_reg;
    logic [9:0]  r_reg;
    logic [1:0]  err_reg;

    logic [14:0] rem_shift;
    logic [14:0] rem_next;
    logic [13:0] quo_next;
    logic        q_bit;
    logic        underflow;
    logic        overflow;

    // One restoring-division step; rem_reg[14] is folded in so the compare
    // stays correct over the full 15-bit partial remainder.
    always_comb begin
        rem_shift = {rem_reg[13:0], d_reg[13]};
        q_bit     = rem_reg[14] | (rem_shift >= {5'd0, b_reg});
        rem_next  = q_bit ? (rem_shift - {5'd0, b_reg}) : rem_shift;
        quo_next  = {quo_reg[12:0], q_bit};
        overflow  = |quo_next[13:10];
        underflow = x_reg < {4'd0, c_reg};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = ((b_reg == 10'd0) || underflow) ? DONE : DIV;
            DIV:     if (cnt_reg == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg   <= '0;
            b_reg   <= '0;
            c_reg   <= '0;
            d_reg   <= '0;
            rem_reg <= '0;
            quo_reg <= '0;
            cnt_reg <= '0;
            a_reg   <= '0;
            r_reg   <= '0;
            err_reg <= ERR_OK;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg   <= X;
                        b_reg   <= B;
                        c_reg   <= C;
                        a_reg   <= '0;
                        r_reg   <= '0;
                        err_reg <= ERR_OK;
                    end
                end
                CHECK: begin
                    if (b_reg == 10'd0) begin
                        err_reg <= ERR_DIV0;
                    end else if (underflow) begin
                        err_reg <= ERR_UNDER;
                    end else begin
                        d_reg   <= x_reg - {4'd0, c_reg};
                        rem_reg <= '0;
                        quo_reg <= '0;
                        cnt_reg <= 4'd13;
                    end
                end
                DIV: begin
                    d_reg   <= {d_reg[12:0], 1'b0};
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    if (cnt_reg == 4'd0) begin
                        // Remainder is always below B, so its low 10 bits are exact.
                        a_reg   <= overflow ? 10'd1023 : quo_next[9:0];
                        r_reg   <= rem_next[9:0];
                        err_reg <= overflow ? ERR_OVER : ERR_OK;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign A    = a_reg;
    assign R    = r_reg;
    assign err  = err_reg;
    assign busy = (state_reg == CHECK) || (state_reg == DIV);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_pipeline_solver.sv
// Directed-vector bench for pipeline_solver: a table of solves plus
// hand-written sequences for held start and reset during division.
module tb_pipeline_solver;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] X;
    logic [9:0]  B;
    logic [9:0]  C;
    logic [9:0]  A;
    logic [9:0]  R;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [13:0] x;
        logic [9:0]  b;
        logic [9:0]  c;
        logic [9:0]  a;
        logic [9:0]  r;
        logic [1:0]  e;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    pipeline_solver dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .B     (B),
        .C     (C),
        .A     (A),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input vec_t v, input string nm);
        int n;
        int bc;
        X = v.x;
        B = v.b;
        C = v.c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        X = 14'($urandom);
        B = 10'($urandom);
        C = 10'($urandom);
        @(negedge clk);
        check({nm, " clr"}, int'({A, R, err}), 0);
        n = 0;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        check({nm, " lat"}, n, v.lat);
        check({nm, " busy"}, bc, v.lat);
        check({nm, " A"}, int'(A), int'(v.a));
        check({nm, " R"}, int'(R), int'(v.r));
        check({nm, " err"}, int'(err), int'(v.e));
        @(negedge clk);
        check({nm, " pulse"}, int'({done, busy}), 0);
    endtask

    initial begin
        int n;
        int dn;

        vecs[0]  = '{x: 14'd100,   b: 10'd7,    c: 10'd2,   a: 10'd14,   r: 10'd0,   e: 2'b00, lat: 15};
        vecs[1]  = '{x: 14'd1000,  b: 10'd30,   c: 10'd5,   a: 10'd33,   r: 10'd5,   e: 2'b00, lat: 15};
        vecs[2]  = '{x: 14'd50,    b: 10'd0,    c: 10'd1,   a: 10'd0,    r: 10'd0,   e: 2'b01, lat: 1};
        vecs[3]  = '{x: 14'd3,     b: 10'd2,    c: 10'd5,   a: 10'd0,    r: 10'd0,   e: 2'b10, lat: 1};
        vecs[4]  = '{x: 14'd16383, b: 10'd1,    c: 10'd0,   a: 10'd1023, r: 10'd0,   e: 2'b11, lat: 15};
        vecs[5]  = '{x: 14'd5,     b: 10'd5,    c: 10'd5,   a: 10'd0,    r: 10'd0,   e: 2'b00, lat: 15};
        vecs[6]  = '{x: 14'd10233, b: 10'd10,   c: 10'd3,   a: 10'd1023, r: 10'd0,   e: 2'b00, lat: 15};
        vecs[7]  = '{x: 14'd10245, b: 10'd10,   c: 10'd0,   a: 10'd1023, r: 10'd5,   e: 2'b11, lat: 15};
        vecs[8]  = '{x: 14'd1029,  b: 10'd1023, c: 10'd5,   a: 10'd1,    r: 10'd1,   e: 2'b00, lat: 15};
        vecs[9]  = '{x: 14'd3,     b: 10'd0,    c: 10'd5,   a: 10'd0,    r: 10'd0,   e: 2'b01, lat: 1};
        vecs[10] = '{x: 14'd4,     b: 10'd3,    c: 10'd5,   a: 10'd0,    r: 10'd0,   e: 2'b10, lat: 1};
        vecs[11] = '{x: 14'd12345, b: 10'd1000, c: 10'd999, a: 10'd11,   r: 10'd346, e: 2'b00, lat: 15};

        rst = 1'b0;
        start = 1'b0;
        X = '0;
        B = '0;
        C = '0;
        repeat (3) @(negedge clk);
        check("reset A", int'(A), 0);
        check("reset R", int'(R), 0);
        check("reset err", int'(err), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);

        // Release at a falling edge and start immediately: first edge must accept.
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        run_op(vecs[1], "hold_setup");
        repeat (3) @(negedge clk);
        check("hold A", int'(A), 33);
        check("hold R", int'(R), 5);
        check("hold err", int'(err), 0);

        // start held high for the whole solve, X disturbed mid-division
        X = 14'd100;
        B = 10'd7;
        C = 10'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                X = 14'd9999;
                B = 10'd3;
            end
        end
        check("held lat", n, 15);
        check("held A", int'(A), 14);
        check("held R", int'(R), 0);
        @(negedge clk);
        check("held idle", int'({busy, done}), 0);
        start = 1'b0;
        @(negedge clk);
        check("held no_restart", int'({busy, done}), 0);

        // reset asserted just after E8 while dividing
        X = 14'd1000;
        B = 10'd30;
        C = 10'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst busy", int'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_async outs", int'({A, R, err, busy, done}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("rst no_done", dn, 0);
        run_op(vecs[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_solver.md
PIPELINE_SOLVER -- requirements
Module: pipeline_solver

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset; 0 = reset.
REQ-003 SHALL have port: start  input  1  request to solve; sampled only in IDLE.
REQ-004 SHALL have port: X  input  14  result word to invert, unsigned.
REQ-005 SHALL have port: B  input  10  divisor operand, unsigned.
REQ-006 SHALL have port: C  input  10  offset operand, unsigned.
REQ-007 SHALL have port: A  output  10  recovered operand, A = (X - C) / B.
REQ-008 SHALL have port: R  output  10  remainder, (X - C) mod B.
REQ-009 SHALL have port: busy  output  1  high in CHECK and DIV.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; A, R and err are valid while it is high.
REQ-011 SHALL have port: err  output  2  00 ok, 01 divide-by-zero, 10 underflow (X < C), 11 overflow (quotient > 1023).

Function
REQ-012 SHALL implement FSM states IDLE, CHECK, DIV and DONE; reset state is IDLE.
REQ-013 SHALL, in IDLE with start=1 at edge E0, latch X, B and C into internal registers and go to CHECK; later changes on X, B or C have no effect.
REQ-014 SHALL, in IDLE with start=0, remain in IDLE.
REQ-015 SHALL ignore start in CHECK, DIV and DONE; there is no queuing.
REQ-016 SHALL, at edge E1 (CHECK), apply these checks in priority order:
- B == 0 -> err=01, go to DONE.
- X < C -> err=10, go to DONE.
- otherwise load 14-bit dividend D = X - C, clear the partial remainder, load iteration counter 13, go to DIV.
REQ-017 SHALL perform one restoring-division step per edge in DIV, MSB first:
- shift the 15-bit partial remainder left and bring in the next D bit;
- if partial remainder >= B, subtract B and set the quotient bit to 1; otherwise set it to 0.
REQ-018 SHALL run exactly 14 DIV iterations (edges E2..E15) and then go to DONE.
REQ-019 SHALL, on leaving DIV with a quotient above 1023, set err=11, A=1023 (saturated) and R = the true remainder; otherwise set err=00, A = quotient[9:0] and R = remainder[9:0].
REQ-020 SHALL give error-path outputs A=0 and R=0.
REQ-021 SHALL assert done for exactly the one cycle spent in DONE:
- normal path: between E15 and E16;
- error path: between E1 and E2.
REQ-022 SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-023 SHALL hold A, R and err after DONE until the next accepted start, which clears them to 0 at its E0.
REQ-024 SHALL keep busy=0 and done=0 in IDLE.
REQ-025 SHALL keep the remainder < B so that R always fits in 10 bits; all arithmetic is unsigned, with no truncation before the final assignment.

Reset
REQ-026 SHALL, on rst=0 asynchronously and without waiting for clk, force state=IDLE, A=0, R=0, err=00, busy=0, done=0, and clear all internal registers.
REQ-027 SHALL, when reset is asserted mid-DIV, abort the operation and produce no done pulse afterward.
REQ-028 SHALL accept a new start on the first rising edge after rst returns to 1.

Verification
REQ-029 SHALL cover: X=100, B=7, C=2, start pulse -> done 15 cycles after the start edge, A=14, R=0, err=00.
REQ-030 SHALL cover: X=1000, B=30, C=5 -> A=33, R=5, err=00; busy high for exactly 15 cycles.
REQ-031 SHALL cover: B=0 (X=50, C=1) -> done one cycle after CHECK, err=01, A=0, R=0; and X=3, C=5, B=2 -> err=10.
REQ-032 SHALL cover: X=16383, B=1, C=0 -> err=11, A=1023, R=0.
REQ-033 SHALL cover: start held high through the whole operation, with X changed during DIV -> a single done, result computed from the latched values, no second start until IDLE.
REQ-034 SHALL cover: rst=0 at E8 during DIV -> all outputs 0 immediately, no done; after rst=1, a new start with X=100, B=7, C=2 -> A=14.
